// File: rtl/spi_slv.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// spi_slv
//
// SPI mode-0 slave bridging a host SPI link onto a 32-bit single-beat register
// bus. The SPI pins are oversampled in the clk domain. Every frame has the same
// fixed layout of 88 sck bits:
//
//   bits  1..8   instruction (0x00 write, 0x01 read, anything else invalid)
//   bits  9..40  address, MSB first
//   read : 41..48 dummy, 49..80 read data out on miso, 81..88 status out
//   write: 41..72 write data in, 73..80 dummy, 81..88 status out
//
// Status byte: [0] ack seen before freeze, [1] bus_err with that ack,
//              [2] invalid instruction, [7:3] zero.
//
// Ports
//   clk, rst_n            system clock, asynchronous active-low reset
//   sck, ss_n, mosi       SPI pins (asynchronous to clk)
//   miso                  SPI slave output, changes after sck falling edges
//   bus_addr, bus_wdata   access address / write data (held after latching)
//   bus_wr, bus_rd        one-clk access strobes, at most one per frame
//   bus_rdata, bus_err    read data / error, valid with bus_ack
//   bus_ack               one-clk access completion
// -----------------------------------------------------------------------------
module spi_slv #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sck,
    input  logic        ss_n,
    input  logic        mosi,
    output logic        miso,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_wr,
    output logic        bus_rd,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    input  logic        bus_err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INSTR,
        ST_ADDR,
        ST_READ,
        ST_WRITE,
        ST_INVALID,
        ST_DONE
    } state_t;

    // Frame bit numbers that trigger actions.
    localparam logic [6:0] BIT_INSTR  = 7'd8;
    localparam logic [6:0] BIT_ADDR   = 7'd40;
    localparam logic [6:0] BIT_RDFRZ  = 7'd48;
    localparam logic [6:0] BIT_WDATA  = 7'd72;
    localparam logic [6:0] BIT_STAT   = 7'd80;
    localparam logic [6:0] BIT_LAST   = 7'd88;
    localparam logic [6:0] BIT_SAT    = 7'd127;

    // -------------------------------------------------------------------------
    // Pin synchroniser chains
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] ss_n_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync  <= '0;
            ss_n_sync <= '1;
            mosi_sync <= '0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0],  sck};
            ss_n_sync <= {ss_n_sync[SYNC_STAGES-2:0], ss_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
        end
    end

    logic sck_p0;
    logic ss_n_p0;
    logic mosi_p0;

    assign sck_p0  = sck_sync[SYNC_STAGES-1];
    assign ss_n_p0 = ss_n_sync[SYNC_STAGES-1];
    assign mosi_p0 = mosi_sync[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // Edge detection: _p1 is the synchronised level one clk later
    // -------------------------------------------------------------------------
    logic sck_p1;
    logic ss_n_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_p1  <= 1'b0;
            ss_n_p1 <= 1'b1;
        end else begin
            sck_p1  <= sck_p0;
            ss_n_p1 <= ss_n_p0;
        end
    end

    logic sck_rise;
    logic sck_fall;
    logic ss_fall;

    assign sck_rise = sck_p0 & ~sck_p1;
    assign sck_fall = ~sck_p0 & sck_p1;
    assign ss_fall  = ~ss_n_p0 & ss_n_p1;

    // -------------------------------------------------------------------------
    // Frame state and datapath
    // -------------------------------------------------------------------------
    state_t      state;
    state_t      state_nxt;
    logic [6:0]  bit_cnt;      // sck rising edges seen in this frame
    logic [6:0]  bit_nxt;      // number of the bit being sampled right now
    logic        is_rd;
    logic        is_wr;
    logic        ack_flag;
    logic        err_flag;
    logic        frozen;       // status captured; later acks are ignored
    logic        acc_busy;     // strobe issued, waiting for its ack
    logic [31:0] rx_shift;
    logic [31:0] rx_nxt;
    logic [31:0] tx_shift;
    logic [31:0] tx_nxt;
    logic [31:0] rdata_cap;
    logic [7:0]  status_byte;
    logic        miso_nxt;
    logic        rd_issue;
    logic        wr_issue;
    logic        frame_on;
    logic        frame_start;
    logic        rise_ev;
    logic        fall_ev;
    logic        freeze_ev;
    logic        ack_take;

    assign frame_start = (state == ST_IDLE) & ss_fall;
    assign frame_on    = (state != ST_IDLE) & ~ss_n_p0;
    assign rise_ev     = frame_on & sck_rise;
    assign fall_ev     = frame_on & sck_fall;
    assign bit_nxt     = bit_cnt + 7'd1;
    assign rx_nxt      = {rx_shift[30:0], mosi_p0};
    assign status_byte = {5'b00000, ~is_rd & ~is_wr, err_flag, ack_flag};

    // Freeze happens on the falling edge that starts the data-out window for
    // reads and the status window for writes. An ack landing in that same clk
    // is rejected so the frozen flags and the shifted-out data always agree.
    assign freeze_ev = fall_ev & ~frozen &
                       ((is_rd & (bit_cnt == BIT_RDFRZ)) |
                        (~is_rd & (bit_cnt == BIT_STAT)));
    assign ack_take  = bus_ack & acc_busy & frame_on & ~frozen & ~freeze_ev;

    // Next-state logic; strobes are decided here so that they are issued on
    // the clk edge that consumes the sck rising-edge event.
    always_comb begin
        state_nxt = state;
        rd_issue  = 1'b0;
        wr_issue  = 1'b0;
        if ((state != ST_IDLE) && ss_n_p0) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ss_fall) state_nxt = ST_INSTR;
                end
                ST_INSTR: begin
                    if (sck_rise && (bit_nxt == BIT_INSTR)) state_nxt = ST_ADDR;
                end
                ST_ADDR: begin
                    if (sck_rise && (bit_nxt == BIT_ADDR)) begin
                        if (is_rd) begin
                            state_nxt = ST_READ;
                            rd_issue  = 1'b1;
                        end else if (is_wr) begin
                            state_nxt = ST_WRITE;
                        end else begin
                            state_nxt = ST_INVALID;
                        end
                    end
                end
                ST_READ, ST_INVALID: begin
                    if (sck_rise && (bit_nxt == BIT_LAST)) state_nxt = ST_DONE;
                end
                ST_WRITE: begin
                    if (sck_rise && (bit_nxt == BIT_WDATA)) wr_issue = 1'b1;
                    if (sck_rise && (bit_nxt == BIT_LAST)) state_nxt = ST_DONE;
                end
                ST_DONE: begin
                    state_nxt = ST_DONE;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // miso source selection, evaluated for the falling edge after bit_cnt bits.
    always_comb begin
        tx_nxt   = {tx_shift[30:0], 1'b0};
        miso_nxt = 1'b0;
        if (is_rd && (bit_cnt == BIT_RDFRZ)) begin
            tx_nxt   = ack_flag ? rdata_cap : 32'h0;
            miso_nxt = tx_nxt[31];
        end else if (is_rd && (bit_cnt > BIT_RDFRZ) && (bit_cnt < BIT_STAT)) begin
            miso_nxt = tx_shift[30];
        end else if (bit_cnt == BIT_STAT) begin
            tx_nxt   = {status_byte, 24'h0};
            miso_nxt = status_byte[7];
        end else if ((bit_cnt > BIT_STAT) && (bit_cnt < BIT_LAST)) begin
            miso_nxt = tx_shift[30];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            is_rd     <= 1'b0;
            is_wr     <= 1'b0;
            ack_flag  <= 1'b0;
            err_flag  <= 1'b0;
            frozen    <= 1'b0;
            acc_busy  <= 1'b0;
            miso      <= 1'b0;
            bus_rd    <= 1'b0;
            bus_wr    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else begin
            state  <= state_nxt;
            bus_rd <= rd_issue;
            bus_wr <= wr_issue;
            if (frame_start) begin
                bit_cnt  <= '0;
                is_rd    <= 1'b0;
                is_wr    <= 1'b0;
                ack_flag <= 1'b0;
                err_flag <= 1'b0;
                frozen   <= 1'b0;
                acc_busy <= 1'b0;
                miso     <= 1'b0;
            end else if (!frame_on) begin
                // Deselected or aborted: drop any outstanding access.
                acc_busy <= 1'b0;
                miso     <= 1'b0;
            end else begin
                if (sck_rise) begin
                    if (bit_cnt != BIT_SAT) bit_cnt <= bit_nxt;
                    if (bit_nxt == BIT_INSTR) begin
                        is_wr <= (rx_nxt[7:0] == 8'h00);
                        is_rd <= (rx_nxt[7:0] == 8'h01);
                    end
                    if (bit_nxt == BIT_ADDR) bus_addr <= rx_nxt;
                end
                if (wr_issue) bus_wdata <= rx_nxt;
                if (rd_issue || wr_issue) begin
                    acc_busy <= 1'b1;
                end else if (ack_take) begin
                    acc_busy <= 1'b0;
                    ack_flag <= 1'b1;
                    err_flag <= bus_err;
                end
                if (freeze_ev) frozen <= 1'b1;
                if (sck_fall) miso <= miso_nxt;
            end
        end
    end

    // Data shifters and read capture; cleared or loaded before every use.
    always_ff @(posedge clk) begin
        if (frame_start) begin
            rx_shift <= '0;
        end else if (rise_ev) begin
            rx_shift <= rx_nxt;
        end
        if (fall_ev) tx_shift <= tx_nxt;
        if (ack_take) rdata_cap <= bus_rdata;
    end

endmodule

// File: tb/tb_spi_slv.sv
`timescale 1ns/1ps
module tb_spi_slv;

    localparam int HALF = 60;   // sck half period: 6 clk periods

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sck;
    logic        ss_n;
    logic        mosi;
    logic        miso;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_wr;
    logic        bus_rd;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [31:0] rd_addr_seen = '0;
    logic [31:0] wr_addr_seen = '0;
    logic [31:0] wr_data_seen = '0;

    logic        ack_en;
    int          ack_delay;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        late_req;

    spi_slv #(.SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sck       (sck),
        .ss_n      (ss_n),
        .mosi      (mosi),
        .miso      (miso),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_wr    (bus_wr),
        .bus_rd    (bus_rd),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    // Strobe monitor: counts every clk a strobe is high, so a wide pulse shows
    // up as a count larger than one.
    always @(negedge clk) begin
        if (bus_rd) begin
            rd_cnt++;
            rd_addr_seen = bus_addr;
        end
        if (bus_wr) begin
            wr_cnt++;
            wr_addr_seen = bus_addr;
            wr_data_seen = bus_wdata;
        end
    end

    // Bus responder, plus an on-demand stray ack for the late-ack scenarios.
    initial begin
        bus_ack   = 1'b0;
        bus_rdata = '0;
        bus_err   = 1'b0;
        forever begin
            @(negedge clk);
            if (late_req) begin
                bus_rdata = 32'hFFFF_FFFF;
                bus_err   = 1'b1;
                bus_ack   = 1'b1;
                @(negedge clk);
                bus_ack   = 1'b0;
                bus_err   = 1'b0;
                bus_rdata = '0;
                late_req  = 1'b0;
            end else if ((bus_rd || bus_wr) && ack_en) begin
                repeat (ack_delay - 1) @(negedge clk);
                bus_rdata = rsp_data;
                bus_err   = rsp_err;
                bus_ack   = 1'b1;
                @(negedge clk);
                bus_ack   = 1'b0;
                bus_err   = 1'b0;
                bus_rdata = '0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // One SPI frame of nbits bits; miso captured at each sck rising edge.
    task automatic spi_xfer(input logic [7:0] ins, input logic [31:0] adr,
                            input logic [31:0] wd, input int nbits,
                            output logic [87:0] rx);
        logic [87:0] tx;
        tx = {ins, adr, wd, 16'h0000};
        rx = '0;
        @(negedge clk);
        ss_n = 1'b0;
        #(HALF);
        for (int i = 1; i <= nbits; i++) begin
            mosi = tx[88-i];
            #(HALF);
            sck = 1'b1;
            rx[88-i] = miso;
            #(HALF);
            sck = 1'b0;
        end
        #(HALF);
        ss_n = 1'b1;
        mosi = 1'b0;
        #(4*HALF);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b expected 0", miso); end
        checks++; if (bus_wr !== 1'b0) begin errors++; $display("FAIL reset_bus_wr: got %b expected 0", bus_wr); end
        checks++; if (bus_rd !== 1'b0) begin errors++; $display("FAIL reset_bus_rd: got %b expected 0", bus_rd); end
        checks++; if (bus_addr !== 32'h0) begin errors++; $display("FAIL reset_bus_addr: got %h expected 0", bus_addr); end
        checks++; if (bus_wdata !== 32'h0) begin errors++; $display("FAIL reset_bus_wdata: got %h expected 0", bus_wdata); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_write();
        logic [87:0] rx;
        int r0, w0;
        r0 = rd_cnt; w0 = wr_cnt;
        ack_en = 1'b1; ack_delay = 3; rsp_err = 1'b0;
        spi_xfer(8'h00, 32'h0000_0010, 32'hDEAD_BEEF, 88, rx);
        checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL wr_pulses: got %0d expected 1", wr_cnt - w0); end
        checks++; if (rd_cnt - r0 !== 0) begin errors++; $display("FAIL wr_no_rd: got %0d expected 0", rd_cnt - r0); end
        checks++; if (wr_addr_seen !== 32'h0000_0010) begin errors++; $display("FAIL wr_addr: got %h expected 00000010", wr_addr_seen); end
        checks++; if (wr_data_seen !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_wdata: got %h expected deadbeef", wr_data_seen); end
        checks++; if (bus_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_wdata_hold: got %h expected deadbeef", bus_wdata); end
        checks++; if (rx[7:0] !== 8'h01) begin errors++; $display("FAIL wr_status: got %h expected 01", rx[7:0]); end
        checks++; if (rx[87:8] !== 80'h0) begin errors++; $display("FAIL wr_miso_idle: got %h expected 0", rx[87:8]); end
    endtask

    task automatic test_read();
        logic [87:0] rx;
        int r0, w0;
        r0 = rd_cnt; w0 = wr_cnt;
        ack_en = 1'b1; ack_delay = 2; rsp_err = 1'b0; rsp_data = 32'h1234_5678;
        spi_xfer(8'h01, 32'h0000_0020, 32'h0, 88, rx);
        checks++; if (rd_cnt - r0 !== 1) begin errors++; $display("FAIL rd_pulses: got %0d expected 1", rd_cnt - r0); end
        checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL rd_no_wr: got %0d expected 0", wr_cnt - w0); end
        checks++; if (rd_addr_seen !== 32'h0000_0020) begin errors++; $display("FAIL rd_addr: got %h expected 00000020", rd_addr_seen); end
        checks++; if (rx[39:8] !== 32'h1234_5678) begin errors++; $display("FAIL rd_data: got %h expected 12345678", rx[39:8]); end
        checks++; if (rx[7:0] !== 8'h01) begin errors++; $display("FAIL rd_status: got %h expected 01", rx[7:0]); end
        checks++; if (rx[87:40] !== 48'h0) begin errors++; $display("FAIL rd_miso_idle: got %h expected 0", rx[87:40]); end
    endtask

    task automatic test_read_noack();
        logic [87:0] rx;
        int r0;
        r0 = rd_cnt;
        ack_en = 1'b0;
        // stray ack around bit 62, after the data window has frozen
        fork
            spi_xfer(8'h01, 32'h0000_0030, 32'h0, 88, rx);
            begin repeat (750) @(negedge clk); late_req = 1'b1; end
        join
        checks++; if (rd_cnt - r0 !== 1) begin errors++; $display("FAIL noack_rd_pulses: got %0d expected 1", rd_cnt - r0); end
        checks++; if (rx[39:8] !== 32'h0) begin errors++; $display("FAIL noack_data: got %h expected 0", rx[39:8]); end
        checks++; if (rx[7:0] !== 8'h00) begin errors++; $display("FAIL noack_status: got %h expected 00", rx[7:0]); end
        // stray ack around bit 25 of the next frame, before its own strobe
        fork
            spi_xfer(8'h01, 32'h0000_0034, 32'h0, 88, rx);
            begin repeat (300) @(negedge clk); late_req = 1'b1; end
        join
        checks++; if (rx[39:8] !== 32'h0) begin errors++; $display("FAIL stale_ack_data: got %h expected 0", rx[39:8]); end
        checks++; if (rx[7:0] !== 8'h00) begin errors++; $display("FAIL stale_ack_status: got %h expected 00", rx[7:0]); end
        ack_en = 1'b1;
    endtask

    task automatic test_invalid();
        logic [87:0] rx;
        int r0, w0;
        r0 = rd_cnt; w0 = wr_cnt;
        ack_en = 1'b1; ack_delay = 2;
        spi_xfer(8'h5A, 32'h0000_0044, 32'h5555_AAAA, 88, rx);
        checks++; if ((rd_cnt - r0) + (wr_cnt - w0) !== 0) begin errors++; $display("FAIL inv_strobes: got %0d expected 0", (rd_cnt - r0) + (wr_cnt - w0)); end
        checks++; if (rx[7:0] !== 8'h04) begin errors++; $display("FAIL inv_status: got %h expected 04", rx[7:0]); end
        checks++; if (rx[87:8] !== 80'h0) begin errors++; $display("FAIL inv_miso_idle: got %h expected 0", rx[87:8]); end
    endtask

    task automatic test_bus_err();
        logic [87:0] rx;
        ack_en = 1'b1; ack_delay = 3; rsp_err = 1'b1; rsp_data = 32'hCAFE_F00D;
        spi_xfer(8'h00, 32'h0000_0050, 32'h0102_0304, 88, rx);
        checks++; if (rx[7:0] !== 8'h03) begin errors++; $display("FAIL wr_err_status: got %h expected 03", rx[7:0]); end
        spi_xfer(8'h01, 32'h0000_0054, 32'h0, 88, rx);
        checks++; if (rx[7:0] !== 8'h03) begin errors++; $display("FAIL rd_err_status: got %h expected 03", rx[7:0]); end
        checks++; if (rx[39:8] !== 32'hCAFE_F00D) begin errors++; $display("FAIL rd_err_data: got %h expected cafef00d", rx[39:8]); end
        rsp_err = 1'b0;
    endtask

    task automatic test_abort();
        logic [87:0] rx;
        int r0, w0;
        r0 = rd_cnt; w0 = wr_cnt;
        ack_en = 1'b1; ack_delay = 2; rsp_err = 1'b0;
        spi_xfer(8'h01, 32'h0000_0060, 32'h0, 20, rx);
        repeat (40) @(negedge clk);
        checks++; if ((rd_cnt - r0) + (wr_cnt - w0) !== 0) begin errors++; $display("FAIL abort_strobes: got %0d expected 0", (rd_cnt - r0) + (wr_cnt - w0)); end
        checks++; if (rx !== 88'h0) begin errors++; $display("FAIL abort_miso: got %h expected 0", rx); end
        checks++; if (miso !== 1'b0) begin errors++; $display("FAIL abort_miso_idle: got %b expected 0", miso); end
        rsp_data = 32'h0BAD_CAFE;
        spi_xfer(8'h01, 32'h0000_0064, 32'h0, 88, rx);
        checks++; if (rx[7:0] !== 8'h01) begin errors++; $display("FAIL post_abort_status: got %h expected 01", rx[7:0]); end
        checks++; if (rx[39:8] !== 32'h0BAD_CAFE) begin errors++; $display("FAIL post_abort_data: got %h expected 0badcafe", rx[39:8]); end
        checks++; if (rd_addr_seen !== 32'h0000_0064) begin errors++; $display("FAIL post_abort_addr: got %h expected 00000064", rd_addr_seen); end
    endtask

    task automatic test_reset_midframe();
        logic [87:0] rx;
        int w0;
        w0 = wr_cnt;
        ack_en = 1'b1; ack_delay = 3;
        fork
            spi_xfer(8'h00, 32'hA5A5_0001, 32'h1111_2222, 88, rx);
            begin
                repeat (600) @(negedge clk);   // around bit 50
                checks++; if (bus_addr !== 32'hA5A5_0001) begin errors++; $display("FAIL midrst_addr_before: got %h expected a5a50001", bus_addr); end
                rst_n = 1'b0;
                #1;
                checks++; if (bus_addr !== 32'h0) begin errors++; $display("FAIL midrst_bus_addr: got %h expected 0", bus_addr); end
                checks++; if (bus_wdata !== 32'h0) begin errors++; $display("FAIL midrst_bus_wdata: got %h expected 0", bus_wdata); end
                checks++; if (miso !== 1'b0) begin errors++; $display("FAIL midrst_miso: got %b expected 0", miso); end
                checks++; if ((bus_rd | bus_wr) !== 1'b0) begin errors++; $display("FAIL midrst_strobes: got %b expected 0", bus_rd | bus_wr); end
            end
        join
        checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL midrst_no_wr: got %0d expected 0", wr_cnt - w0); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        rsp_data = 32'h7654_3210;
        spi_xfer(8'h01, 32'h0000_0070, 32'h0, 88, rx);
        checks++; if (rx[39:8] !== 32'h7654_3210) begin errors++; $display("FAIL post_rst_data: got %h expected 76543210", rx[39:8]); end
        checks++; if (rx[7:0] !== 8'h01) begin errors++; $display("FAIL post_rst_status: got %h expected 01", rx[7:0]); end
    endtask

    initial begin
        rst_n     = 1'b0;
        sck       = 1'b0;
        ss_n      = 1'b1;
        mosi      = 1'b0;
        ack_en    = 1'b1;
        ack_delay = 3;
        rsp_data  = '0;
        rsp_err   = 1'b0;
        late_req  = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_read_noack();
        test_invalid();
        test_bus_err();
        test_abort();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
